// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: lock-state encoding, owner encoding
// and the width of the starvation wait counter.
package mem_arb_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_P = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_C = 1'b0,
        OWNER_P = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory port arbiter.
// ARB_ROUND_ROBIN_EN swaps the fixed-priority/starvation-guard rules for round-robin.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  arb_state_t              state,
    input  logic                    c_req,
    input  logic                    p_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_t                  rr_last,
`else
    input  logic [WAIT_CNT_W-1:0]   wait_cnt,
`endif
    output logic                    c_win,
    output logic                    p_win
);

`ifndef ARB_ROUND_ROBIN_EN
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MAX_WAIT);
`endif

    always_comb begin
        c_win = 1'b0;
        p_win = 1'b0;
        // A locked owner keeps the port even against a starving P.
        if (state == OWN_C && c_req) begin
            c_win = 1'b1;
        end else if (state == OWN_P && p_req) begin
            p_win = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        end else if (c_req && p_req) begin
            if (rr_last == OWNER_P) c_win = 1'b1;
            else                    p_win = 1'b1;
`else
        end else if (p_req && wait_cnt == WAIT_MAX) begin
            p_win = 1'b1;
`endif
        end else if (c_req) begin
            c_win = 1'b1;
        end else if (p_req) begin
            p_win = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single RAM/MMIO data port (CPU = C, peripheral = P).
// Build option ARB_ROUND_ROBIN_EN: round-robin instead of C priority + starvation guard.
//
//   state | meaning
//   IDLE  | no owner, winner chosen by priority rules
//   OWN_C | CPU holds a lock, keeps the port while c_req stays high
//   OWN_P | peripheral holds a lock, keeps the port while p_req stays high
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 10,
    parameter int MAX_WAIT      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_req,
    input  logic                     c_we,
    input  logic                     c_lock,
    input  logic [RAM_ADDR_BITS-1:0] c_adr,
    input  logic [WIDTH-1:0]         c_wdata,
    output logic                     c_gnt,
    output logic                     c_rvalid,
    output logic [WIDTH-1:0]         c_rdata,
    input  logic                     p_req,
    input  logic                     p_we,
    input  logic                     p_lock,
    input  logic [RAM_ADDR_BITS-1:0] p_adr,
    input  logic [WIDTH-1:0]         p_wdata,
    output logic                     p_gnt,
    output logic                     p_rvalid,
    output logic [WIDTH-1:0]         p_rdata,
    output logic                     mem_en,
    output logic                     mem_write,
    output logic                     mem_read,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata
);

    arb_state_t state, state_nxt;
    logic       c_win, p_win;
    logic       tag1_v, tag2_v;
    owner_t     tag1_own, tag2_own;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t rr_last;
`else
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MAX_WAIT);
    logic [WAIT_CNT_W-1:0] wait_cnt;
`endif

    mem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .state    (state),
        .c_req    (c_req),
        .p_req    (p_req),
`ifdef ARB_ROUND_ROBIN_EN
        .rr_last  (rr_last),
`else
        .wait_cnt (wait_cnt),
`endif
        .c_win    (c_win),
        .p_win    (p_win)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // An owner that drops req or takes an unlocked grant falls back to IDLE.
    always_comb begin
        c_gnt     = c_win & ~rst;
        p_gnt     = p_win & ~rst;
        state_nxt = IDLE;
        if (c_gnt) begin
            state_nxt = c_lock ? OWN_C : IDLE;
        end else if (p_gnt) begin
            state_nxt = p_lock ? OWN_P : IDLE;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= OWNER_P;
        end else if (c_gnt && !c_lock) begin
            rr_last <= OWNER_C;
        end else if (p_gnt && !p_lock) begin
            rr_last <= OWNER_P;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (p_req && !p_gnt) begin
            if (wait_cnt < WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    // Address and write data hold across idle cycles; only the strobes drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
        end else if (c_gnt) begin
            mem_en    <= 1'b1;
            mem_write <= c_we;
            mem_read  <= ~c_we;
            mem_adr   <= c_adr;
            mem_wdata <= c_wdata;
        end else if (p_gnt) begin
            mem_en    <= 1'b1;
            mem_write <= p_we;
            mem_read  <= ~p_we;
            mem_adr   <= p_adr;
            mem_wdata <= p_wdata;
        end else begin
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_v   <= 1'b0;
            tag1_own <= OWNER_C;
            tag2_v   <= 1'b0;
            tag2_own <= OWNER_C;
        end else begin
            tag1_v   <= (c_gnt & ~c_we) | (p_gnt & ~p_we);
            tag1_own <= p_gnt ? OWNER_P : OWNER_C;
            tag2_v   <= tag1_v;
            tag2_own <= tag1_own;
        end
    end

    assign c_rvalid = tag2_v && (tag2_own == OWNER_C);
    assign p_rvalid = tag2_v && (tag2_own == OWNER_P);
    assign c_rdata  = mem_rdata;
    assign p_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, read-return scoreboard and scenario tasks.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int W  = 16;
    localparam int AB = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
    logic [AB-1:0] c_adr = '0;
    logic [W-1:0]  c_wdata = '0;
    logic          p_req = 1'b0, p_we = 1'b0, p_lock = 1'b0;
    logic [AB-1:0] p_adr = '0;
    logic [W-1:0]  p_wdata = '0;
    logic          c_gnt, c_rvalid, p_gnt, p_rvalid;
    logic [W-1:0]  c_rdata, p_rdata;
    logic          mem_en, mem_write, mem_read;
    logic [AB-1:0] mem_adr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata = '0;

    logic [W-1:0]  ram [0:(1<<AB)-1];
    logic          ram_ready = 1'b0;

    typedef struct {
        logic         own;
        logic [W-1:0] data;
        int           cyc;
    } sb_t;
    sb_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .p_req(p_req), .p_we(p_we), .p_lock(p_lock), .p_adr(p_adr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .mem_en(mem_en), .mem_write(mem_write), .mem_read(mem_read),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM model: read data appears the cycle after the access cycle.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < (1 << AB); i++) ram[i] <= 16'h5000 ^ W'(i);
            ram[12]   <= 16'hABCD;
            ram_ready <= 1'b1;
        end else if (mem_en && mem_write) begin
            ram[mem_adr] <= mem_wdata;
        end
        mem_rdata <= (mem_en && mem_read) ? ram[mem_adr] : '0;
    end

    // Scoreboard: every read grant expects its rvalid exactly two cycles later.
    always @(negedge clk) begin
        sb_t e;
        cyc++;
        if (rst) begin
            sb.delete();
        end else begin
            if (c_rvalid || p_rvalid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_spurious: cyc %0d rvalid c=%b p=%b, expected none", cyc, c_rvalid, p_rvalid);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || (c_rvalid && p_rvalid) || p_rvalid !== e.own ||
                        (p_rvalid ? p_rdata : c_rdata) !== e.data) begin
                        miscompares++;
                        $display("FAIL sb_read: cyc %0d got own=%b data=%h, expected cyc %0d own=%b data=%h",
                                 cyc, p_rvalid, (p_rvalid ? p_rdata : c_rdata), e.cyc, e.own, e.data);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_missing: cyc %0d no rvalid, expected own=%b data=%h", cyc, sb[0].own, sb[0].data);
                void'(sb.pop_front());
            end
            if (c_gnt && !c_we) begin
                e.own = 1'b0; e.data = ram[c_adr]; e.cyc = cyc + 2;
                sb.push_back(e);
            end
            if (p_gnt && !p_we) begin
                e.own = 1'b1; e.data = ram[p_adr]; e.cyc = cyc + 2;
                sb.push_back(e);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all;
        c_req = 1'b0; c_we = 1'b0; c_lock = 1'b0;
        p_req = 1'b0; p_we = 1'b0; p_lock = 1'b0;
    endtask

    task automatic test_reset;
        c_req = 1'b1; p_req = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        vectors++;
        if ({c_gnt, p_gnt, c_rvalid, p_rvalid, mem_en, mem_write, mem_read} !== 7'b0 ||
            mem_adr !== '0 || mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b en/wr/rd=%b%b%b adr=%h wd=%h, expected all 0",
                     c_gnt, p_gnt, c_rvalid, p_rvalid, mem_en, mem_write, mem_read, mem_adr, mem_wdata);
        end
        tick();
        drop_all();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read;
        logic exp_en, exp_rv;
        c_req = 1'b1; c_we = 1'b0; c_adr = 10'd12;
        @(negedge clk);
        vectors++;
        if ({c_gnt, p_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL rd_gnt: got c/p gnt %b, expected 10", {c_gnt, p_gnt});
        end
        tick();
        c_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_en, mem_read, mem_write} !== 3'b110 || mem_adr !== 10'd12) begin
            miscompares++;
            $display("FAIL rd_cmd: got en/rd/wr=%b%b%b adr=%0d, expected 110 adr=12", mem_en, mem_read, mem_write, mem_adr);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (c_rvalid !== 1'b1 || c_rdata !== 16'hABCD) begin
            miscompares++;
            $display("FAIL rd_data: got rvalid=%b rdata=%h, expected 1 abcd", c_rvalid, c_rdata);
        end
        tick();
        for (int j = 0; j < 6; j++) begin
            c_req = (j < 3);
            c_adr = AB'(j + 1);
            @(negedge clk);
            exp_en = (j >= 1 && j <= 3);
            exp_rv = (j >= 2 && j <= 4);
            vectors++;
            if (c_gnt !== (j < 3) || mem_en !== exp_en || (exp_en && mem_adr !== AB'(j)) ||
                c_rvalid !== exp_rv || (exp_rv && c_rdata !== ram[j - 1])) begin
                miscompares++;
                $display("FAIL b2b_%0d: got gnt=%b en=%b adr=%0d rv=%b, expected gnt=%b en=%b adr=%0d rv=%b",
                         j, c_gnt, mem_en, mem_adr, c_rvalid, (j < 3), exp_en, j, exp_rv);
            end
            tick();
        end
    endtask

    task automatic test_simultaneous;
        logic exp_p;
        for (int j = 0; j < 6; j++) begin
            c_req = 1'b1; c_adr = AB'(20 + j);
            p_req = 1'b1; p_adr = AB'(40 + j);
            @(negedge clk);
            exp_p = (j == 4);
            vectors++;
            if ({c_gnt, p_gnt} !== {~exp_p, exp_p}) begin
                miscompares++;
                $display("FAIL starve_%0d: got c/p gnt %b%b, expected %b%b", j, c_gnt, p_gnt, ~exp_p, exp_p);
            end
            tick();
        end
        drop_all();
        repeat (3) tick();
    endtask

    task automatic test_lock_p;
        logic exp_p, exp_c;
        for (int j = 0; j < 4; j++) begin
            p_req = (j < 3); p_lock = (j < 2); p_adr = AB'(60 + j);
            c_req = (j >= 1); c_adr = 10'd70;
            @(negedge clk);
            exp_p = (j < 3);
            exp_c = (j == 3);
            vectors++;
            if ({c_gnt, p_gnt} !== {exp_c, exp_p}) begin
                miscompares++;
                $display("FAIL lock_p_%0d: got c/p gnt %b%b, expected %b%b", j, c_gnt, p_gnt, exp_c, exp_p);
            end
            tick();
        end
        drop_all();
        repeat (3) tick();
    endtask

    task automatic test_lock_c;
        logic exp_p;
        for (int j = 0; j < 8; j++) begin
            c_req = 1'b1; c_lock = (j < 6); c_adr = 10'd80;
            p_req = 1'b1; p_adr = 10'd90;
            @(negedge clk);
            exp_p = (j == 7);
            vectors++;
            if ({c_gnt, p_gnt} !== {~exp_p, exp_p}) begin
                miscompares++;
                $display("FAIL lock_c_%0d: got c/p gnt %b%b, expected %b%b", j, c_gnt, p_gnt, ~exp_p, exp_p);
            end
            tick();
        end
        drop_all();
        repeat (3) tick();
    endtask

    task automatic test_write;
        p_req = 1'b1; p_we = 1'b1; p_adr = 10'd530; p_wdata = 16'd1;
        @(negedge clk);
        vectors++;
        if ({c_gnt, p_gnt} !== 2'b01) begin
            miscompares++;
            $display("FAIL wr_gnt: got c/p gnt %b%b, expected 01", c_gnt, p_gnt);
        end
        tick();
        drop_all();
        c_req = 1'b1; c_we = 1'b1; c_adr = 10'd531; c_wdata = 16'h1234;
        @(negedge clk);
        vectors++;
        if ({mem_en, mem_write, mem_read} !== 3'b110 || mem_adr !== 10'd530 || mem_wdata !== 16'd1 || p_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_cmd_p: got en/wr/rd=%b%b%b adr=%0d wd=%h rv=%b, expected 110 adr=530 wd=0001 rv=0",
                     mem_en, mem_write, mem_read, mem_adr, mem_wdata, p_rvalid);
        end
        tick();
        c_req = 1'b0; c_we = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_en, mem_write, mem_read} !== 3'b110 || mem_adr !== 10'd531 || mem_wdata !== 16'h1234 ||
            p_rvalid !== 1'b0 || c_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_cmd_c: got en/wr/rd=%b%b%b adr=%0d wd=%h rv=%b%b, expected 110 adr=531 wd=1234 rv=00",
                     mem_en, mem_write, mem_read, mem_adr, mem_wdata, c_rvalid, p_rvalid);
        end
        tick();
        c_req = 1'b1; c_we = 1'b0; c_adr = 10'd530;
        @(negedge clk);
        vectors++;
        if (p_rvalid !== 1'b0 || c_rvalid !== 1'b0 || mem_en !== 1'b0 || mem_adr !== 10'd531) begin
            miscompares++;
            $display("FAIL wr_idle: got rv=%b%b en=%b adr=%0d, expected rv=00 en=0 adr=531 held", c_rvalid, p_rvalid, mem_en, mem_adr);
        end
        tick();
        c_req = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if (c_rvalid !== 1'b1 || c_rdata !== 16'd1) begin
            miscompares++;
            $display("FAIL wr_readback: got rv=%b rdata=%h, expected 1 0001", c_rvalid, c_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        c_req = 1'b1; c_we = 1'b0; c_adr = 10'd7;
        @(negedge clk);
        vectors++;
        if (c_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_gnt: got c_gnt=%b, expected 1", c_gnt);
        end
        tick();
        rst = 1'b1;
        p_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({c_gnt, p_gnt} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_gnt_forced: got c/p gnt %b%b, expected 00", c_gnt, p_gnt);
        end
        tick();
        drop_all();
        @(negedge clk);
        vectors++;
        if ({c_gnt, p_gnt, c_rvalid, p_rvalid, mem_en, mem_write, mem_read} !== 7'b0 ||
            mem_adr !== '0 || mem_wdata !== '0 || dut.state !== IDLE) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got gnt=%b%b rv=%b%b en/wr/rd=%b%b%b adr=%h wd=%h st=%0d, expected all 0 IDLE",
                     c_gnt, p_gnt, c_rvalid, p_rvalid, mem_en, mem_write, mem_read, mem_adr, mem_wdata, dut.state);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (c_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_squash: got c_rvalid=%b, expected 0", c_rvalid);
        end
        tick();
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    task automatic test_round_robin;
        logic exp_c;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            c_req = 1'b1; c_adr = AB'(100 + j);
            p_req = 1'b1; p_adr = AB'(120 + j);
            @(negedge clk);
            exp_c = (j % 2 == 0);
            vectors++;
            if ({c_gnt, p_gnt} !== {exp_c, ~exp_c}) begin
                miscompares++;
                $display("FAIL rr_%0d: got c/p gnt %b%b, expected %b%b", j, c_gnt, p_gnt, exp_c, ~exp_c);
            end
            tick();
        end
        drop_all();
        repeat (3) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_read();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_simultaneous();
        test_lock_c();
`endif
        test_lock_p();
        test_write();
        test_reset_mid();
        repeat (4) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending reads, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, expected finish");
        $fatal(1, "watchdog timeout");
    end

endmodule
